// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller: sequences 24-bit commands from a synchronous ROM,
// resolves operands through data memory and drives the ALU start/done handshake.
module instruction_sequencer #(
  parameter logic [7:0] RESET_IP = 8'h00
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        run,
  output logic [7:0]  instrAddr,
  input  logic [23:0] instrData,
  output logic [7:0]  memAddr,
  input  logic [7:0]  memRdData,
  output logic        memWrEn,
  output logic [7:0]  memWrData,
  output logic [1:0]  aluOp,
  output logic [7:0]  aluA,
  output logic [7:0]  aluB,
  output logic        aluStart,
  input  logic        aluDone,
  input  logic [7:0]  aluResult,
  output logic [7:0]  accOut,
  output logic [7:0]  instructionPointer,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RD1A, S_RD1D, S_RD2A, S_RD2D,
    S_EXEC, S_WAIT, S_WRITE, S_HALT
  } state_t;

  typedef enum logic [5:0] {
    OP_NOP = 6'h00, OP_ADD = 6'h01, OP_SUB = 6'h02, OP_INV = 6'h03,
    OP_MOV = 6'h04, OP_JFE = 6'h05, OP_JFL = 6'h06, OP_JFG = 6'h07,
    OP_HALT = 6'h3F
  } opcode_t;

  state_t      state, state_d;
  logic [23:0] instr_q, cmd;
  logic [5:0]  opcode;
  logic        flag1, flag2;
  logic [7:0]  field1, field2;
  logic        is_alu, is_jump, is_mov, is_illegal, need_rd1, need_rd2, wr_mem, taken;
  logic [7:0]  op1_d, op2_d, result_q, ip_next;

  // The command is decoded straight off the ROM bus in DECODE, from the latched copy afterwards.
  assign cmd    = (state == S_DECODE) ? instrData : instr_q;
  assign opcode = cmd[23:18];
  assign flag1  = cmd[17];
  assign field1 = cmd[16:9];
  assign flag2  = cmd[8];
  assign field2 = cmd[7:0];

  assign is_alu     = opcode inside {OP_ADD, OP_SUB, OP_INV};
  assign is_jump    = opcode inside {OP_JFE, OP_JFL, OP_JFG};
  assign is_mov     = (opcode == OP_MOV);
  assign is_illegal = !(is_alu || is_jump || is_mov || opcode == OP_NOP || opcode == OP_HALT)
                      || (is_mov && !flag1);
  assign need_rd1   = flag1 && (is_alu || is_jump);
  assign need_rd2   = flag2 && (opcode inside {OP_ADD, OP_SUB, OP_MOV});
  assign wr_mem     = is_mov || (is_alu && flag1);

  assign aluStart = (state == S_EXEC);
  assign memWrEn  = (state == S_WRITE) && wr_mem;
  assign halted   = (state == S_HALT);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_JFE:  taken = (accOut == aluA);
      OP_JFL:  taken = (accOut <  aluA);
      OP_JFG:  taken = (accOut >  aluA);
      default: taken = 1'b0;
    endcase
    ip_next = taken ? field2 : instructionPointer + 8'd1;

    op1_d = aluA;
    op2_d = aluB;
    if (state == S_DECODE) begin
      if ((is_alu || is_jump) && !flag1) op1_d = field1;
      if ((opcode inside {OP_ADD, OP_SUB, OP_MOV}) && !flag2) op2_d = field2;
    end
    if (state == S_RD1D) op1_d = memRdData;
    if (state == S_RD2D) op2_d = memRdData;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_illegal || opcode == OP_HALT) state_d = S_HALT;
        else if (need_rd1)                   state_d = S_RD1A;
        else if (need_rd2)                   state_d = S_RD2A;
        else if (is_alu)                     state_d = S_EXEC;
        else                                 state_d = S_WRITE;
      end
      S_RD1A:   state_d = S_RD1D;
      S_RD1D: begin
        if (need_rd2)    state_d = S_RD2A;
        else if (is_alu) state_d = S_EXEC;
        else             state_d = S_WRITE;
      end
      S_RD2A:   state_d = S_RD2D;
      S_RD2D:   state_d = is_alu ? S_EXEC : S_WRITE;
      S_EXEC:   state_d = S_WAIT;
      S_WAIT:   if (aluDone) state_d = S_WRITE;
      S_WRITE:  state_d = run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_d;
  end

  // NOTE: the latched command and result are reset too, so nothing left from an abandoned
  // instruction can leak into the first one after reset.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      instructionPointer <= RESET_IP;
      instrAddr          <= 8'h00;
      instr_q            <= 24'h0;
      memAddr            <= 8'h00;
      memWrData          <= 8'h00;
      aluOp              <= 2'b00;
      aluA               <= 8'h00;
      aluB               <= 8'h00;
      result_q           <= 8'h00;
      accOut             <= 8'h00;
      illegal            <= 1'b0;
    end else begin
      aluA <= op1_d;
      aluB <= op2_d;

      if (state == S_DECODE) begin
        instr_q <= instrData;
        if (is_illegal) illegal <= 1'b1;
        if (is_alu) begin
          case (opcode)
            OP_SUB:  aluOp <= 2'b01;
            OP_INV:  aluOp <= 2'b10;
            default: aluOp <= 2'b00;
          endcase
        end
      end

      if (state_d == S_RD1A)      memAddr <= field1;
      else if (state_d == S_RD2A) memAddr <= field2;
      else if (state_d == S_WRITE && wr_mem) begin
        memAddr   <= field1;
        memWrData <= is_mov ? op2_d : aluResult;
      end

      if (state == S_WAIT && aluDone) result_q <= aluResult;

      if (state == S_WRITE) begin
        instructionPointer <= ip_next;
        if (is_alu && !flag1) accOut <= result_q;
      end

      if (state_d == S_FETCH) instrAddr <= (state == S_WRITE) ? ip_next : instructionPointer;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: ROM, data memory and a 1-cycle ALU modelled
// around the DUT, with hand-computed expectations checked by immediate assertions.
module tb_instruction_sequencer;

  localparam logic [5:0] NOP = 6'h00, ADD = 6'h01, SUB = 6'h02, INV = 6'h03, MOV = 6'h04;
  localparam logic [5:0] JFE = 6'h05, JFL = 6'h06, JFG = 6'h07, HLT = 6'h3F, BAD = 6'b101010;

  logic        clock = 1'b0;
  logic        resetN, run;
  logic [7:0]  instrAddr, memAddr, memWrData, aluA, aluB, accOut, instructionPointer;
  logic [23:0] instrData = 24'h0;
  logic [7:0]  memRdData = 8'h00, aluResult = 8'h00;
  logic        memWrEn, aluStart, halted, illegal;
  logic        aluDone = 1'b0;
  logic [1:0]  aluOp;

  logic [23:0] rom [256];
  logic [7:0]  mem [256];
  logic        mem_ready = 1'b0;
  logic        alu_auto, late_done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  alu_starts = 8'd0, wr_count = 8'd0;
  logic [7:0]  st_a = 8'h00, st_b = 8'h00, wr_addr = 8'h00, wr_data = 8'h00;
  logic [1:0]  st_op = 2'b00;
  logic [7:0]  prev_ia = 8'h00, last_delta = 8'h00;
  logic [15:0] cyc = 16'd0, ia_cyc = 16'd0;
  logic [7:0]  s0, w0;

  instruction_sequencer #(.RESET_IP(8'h10)) dut (
    .clock(clock), .resetN(resetN), .run(run),
    .instrAddr(instrAddr), .instrData(instrData),
    .memAddr(memAddr), .memRdData(memRdData), .memWrEn(memWrEn), .memWrData(memWrData),
    .aluOp(aluOp), .aluA(aluA), .aluB(aluB), .aluStart(aluStart),
    .aluDone(aluDone), .aluResult(aluResult),
    .accOut(accOut), .instructionPointer(instructionPointer),
    .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  always @(posedge clock) instrData <= rom[instrAddr];

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h20] <= 8'h05;
      mem[8'h21] <= 8'hF0;
      mem[8'h22] <= 8'h80;
      mem[8'h23] <= 8'h90;
      mem[8'h31] <= 8'hA5;
      mem_ready  <= 1'b1;
    end else begin
      memRdData <= mem[memAddr];
      if (memWrEn) mem[memAddr] <= memWrData;
    end
  end

  // One-cycle ALU: answers the cycle after aluStart unless stalled; late_done injects a stray pulse.
  always @(posedge clock) begin
    if (late_done) begin
      aluDone   <= 1'b1;
      aluResult <= 8'h77;
    end else if (alu_auto && aluStart) begin
      aluDone <= 1'b1;
      case (aluOp)
        2'b00:   aluResult <= aluA + aluB;
        2'b01:   aluResult <= aluA - aluB;
        default: aluResult <= ~aluA;
      endcase
    end else begin
      aluDone <= 1'b0;
    end
  end

  always @(negedge clock) begin
    cyc = cyc + 16'd1;
    if (aluStart) begin
      alu_starts = alu_starts + 8'd1;
      st_a = aluA;
      st_b = aluB;
      st_op = aluOp;
    end
    if (memWrEn) begin
      wr_count = wr_count + 8'd1;
      wr_addr = memAddr;
      wr_data = memWrData;
    end
    if (instrAddr != prev_ia) begin
      last_delta = 8'(cyc - ia_cyc);
      ia_cyc = cyc;
      prev_ia = instrAddr;
    end
  end

  function automatic logic [23:0] enc(input logic [5:0] op, input logic f1, input logic [7:0] a,
                                      input logic f2, input logic [7:0] b);
    return {op, f1, a, f2, b};
  endfunction

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_ip(input string tag, input logic [7:0] target, input int budget);
    for (int i = 0; i < budget && instructionPointer !== target; i++) step();
    check(tag, instructionPointer, target);
  endtask

  task automatic wait_halt(input string tag, input int budget);
    for (int i = 0; i < budget && halted !== 1'b1; i++) step();
    check(tag, 8'(halted), 8'h01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN = 1'b0; run = 1'b0; alu_auto = 1'b1; late_done = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 24'h0;
    rom[8'h10] = enc(ADD, 1'b0, 8'h03, 1'b0, 8'h05);
    rom[8'h11] = enc(SUB, 1'b1, 8'h20, 1'b0, 8'h07);
    rom[8'h12] = enc(ADD, 1'b0, 8'h04, 1'b0, 8'h05);
    rom[8'h13] = enc(JFE, 1'b0, 8'h09, 1'b0, 8'h40);
    rom[8'h40] = enc(JFG, 1'b0, 8'h09, 1'b0, 8'h50);
    rom[8'h41] = enc(JFL, 1'b0, 8'h0A, 1'b0, 8'h60);
    rom[8'h60] = enc(INV, 1'b0, 8'h0F, 1'b1, 8'h99);
    rom[8'h61] = enc(JFE, 1'b1, 8'h21, 1'b0, 8'hFF);
    rom[8'hFF] = enc(NOP, 1'b0, 8'h00, 1'b0, 8'h00);
    rom[8'h00] = enc(MOV, 1'b1, 8'h30, 1'b1, 8'h31);
    rom[8'h01] = enc(ADD, 1'b1, 8'h22, 1'b1, 8'h23);
    rom[8'h02] = enc(BAD, 1'b0, 8'h00, 1'b0, 8'h00);
    repeat (3) step();

    check("rst_instrAddr", instrAddr, 8'h00);
    check("rst_ip", instructionPointer, 8'h10);
    check("rst_acc", accOut, 8'h00);
    check("rst_halted", 8'(halted), 8'h00);
    check("rst_illegal", 8'(illegal), 8'h00);
    check("rst_aluStart", 8'(aluStart), 8'h00);
    check("rst_memWrEn", 8'(memWrEn), 8'h00);

    // ADD imm 3, imm 5 into the accumulator
    resetN = 1'b1; run = 1'b1;
    wait_ip("add_ip", 8'h11, 20);
    check("add_acc", accOut, 8'h08);
    check("add_starts", alu_starts, 8'd1);
    check("add_aluA", st_a, 8'h03);
    check("add_aluB", st_b, 8'h05);
    check("add_aluOp", 8'(st_op), 8'h00);
    check("add_no_write", wr_count, 8'd0);
    check("add_latency", last_delta, 8'd5);

    // SUB mem[0x20] - imm 7 back into mem[0x20]
    wait_ip("sub_ip", 8'h12, 30);
    check("sub_aluA", st_a, 8'h05);
    check("sub_aluB", st_b, 8'h07);
    check("sub_aluOp", 8'(st_op), 8'h01);
    check("sub_wr_count", wr_count, 8'd1);
    check("sub_wr_addr", wr_addr, 8'h20);
    check("sub_wr_data", wr_data, 8'hFE);
    check("sub_mem", mem[8'h20], 8'hFE);
    check("sub_acc_kept", accOut, 8'h08);
    check("sub_latency", last_delta, 8'd7);

    wait_ip("acc9_ip", 8'h13, 20);
    check("acc9", accOut, 8'h09);

    // Three conditional jumps with accOut = 9
    s0 = alu_starts; w0 = wr_count;
    wait_ip("jfe_taken", 8'h40, 20);
    check("jfe_latency", last_delta, 8'd3);
    wait_ip("jfg_not_taken", 8'h41, 20);
    wait_ip("jfl_taken", 8'h60, 20);
    check("jump_no_alu", alu_starts, s0);
    check("jump_no_write", wr_count, w0);
    check("jump_memAddr_kept", memAddr, 8'h20);

    // INV ignores op2 even when flagged as an address
    wait_ip("inv_ip", 8'h61, 20);
    check("inv_acc", accOut, 8'hF0);
    check("inv_aluA", st_a, 8'h0F);
    check("inv_aluOp", 8'(st_op), 8'h02);
    check("inv_latency", last_delta, 8'd5);
    check("inv_no_op2_read", memAddr, 8'h20);

    wait_ip("jfe_mem_taken", 8'hFF, 20);
    wait_ip("nop_wrap", 8'h00, 20);

    // MOV mem[0x30] <- mem[0x31], run dropped while the operand read is in flight
    w0 = wr_count;
    for (int i = 0; i < 10 && memAddr !== 8'h31; i++) step();
    check("mov_rd_addr", memAddr, 8'h31);
    step();
    run = 1'b0;
    repeat (4) step();
    check("mov_mem", mem[8'h30], 8'hA5);
    check("mov_wr_count", wr_count, w0 + 8'd1);
    check("mov_wr_addr", wr_addr, 8'h30);
    check("mov_ip", instructionPointer, 8'h01);
    check("idle_instrAddr", instrAddr, 8'h00);
    repeat (3) step();
    check("idle_hold", instrAddr, 8'h00);
    run = 1'b1;
    for (int i = 0; i < 5 && instrAddr !== 8'h01; i++) step();
    check("resume_fetch", instrAddr, 8'h01);

    // ADD with both operands from memory, result wraps mod 256
    wait_ip("add_mem_ip", 8'h02, 30);
    check("add_mem_result", mem[8'h22], 8'h10);
    check("add_mem_aluA", st_a, 8'h80);
    check("add_mem_aluB", st_b, 8'h90);
    check("add_mem_latency", last_delta, 8'd9);

    // Illegal opcode halts and freezes fetch
    wait_halt("illegal_halted", 10);
    check("illegal_flag", 8'(illegal), 8'h01);
    check("illegal_ip", instructionPointer, 8'h02);
    repeat (4) step();
    check("illegal_hold", instrAddr, 8'h02);

    resetN = 1'b0;
    #1;
    check("rst2_halted", 8'(halted), 8'h00);
    check("rst2_illegal", 8'(illegal), 8'h00);
    check("rst2_ip", instructionPointer, 8'h10);
    rom[8'h11] = enc(ADD, 1'b0, 8'h01, 1'b0, 8'h01);
    rom[8'h12] = enc(HLT, 1'b0, 8'h00, 1'b0, 8'h00);
    step();
    resetN = 1'b1;
    wait_ip("p2_add_ip", 8'h11, 20);
    check("p2_add_acc", accOut, 8'h08);

    // Stall the ALU, then reset asynchronously in the middle of WAIT
    alu_auto = 1'b0;
    s0 = alu_starts;
    for (int i = 0; i < 10 && alu_starts === s0; i++) step();
    check("stall_start_seen", alu_starts, s0 + 8'd1);
    step();
    #2;
    resetN = 1'b0;
    #1;
    check("midrst_instrAddr", instrAddr, 8'h00);
    check("midrst_ip", instructionPointer, 8'h10);
    check("midrst_acc", accOut, 8'h00);
    check("midrst_aluA", aluA, 8'h00);
    check("midrst_aluB", aluB, 8'h00);
    check("midrst_aluOp", 8'(aluOp), 8'h00);
    check("midrst_aluStart", 8'(aluStart), 8'h00);
    check("midrst_memAddr", memAddr, 8'h00);
    check("midrst_memWrEn", 8'(memWrEn), 8'h00);
    check("midrst_memWrData", memWrData, 8'h00);
    step();
    alu_auto = 1'b1;
    resetN = 1'b1;
    late_done = 1'b1;
    step();
    late_done = 1'b0;
    repeat (3) step();
    check("late_done_ignored", accOut, 8'h00);
    check("restart_fetch", instrAddr, 8'h10);
    wait_ip("p2_readd_ip", 8'h11, 20);
    check("p2_readd_acc", accOut, 8'h08);
    wait_ip("p2_add11_ip", 8'h12, 20);
    check("p2_add11_acc", accOut, 8'h02);

    // HALT opcode stops with IP on the HALT word and no illegal flag
    wait_halt("halt_halted", 10);
    check("halt_not_illegal", 8'(illegal), 8'h00);
    check("halt_ip", instructionPointer, 8'h12);
    repeat (3) step();
    check("halt_hold", instrAddr, 8'h12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
